// File: rtl/run_controller_pkg.sv
// Shared types and defaults for the run sequencer: FSM state encoding and
// default parameter values used by run_controller and its testbench.
package run_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam int unsigned DEF_CW           = 16;
    localparam int unsigned DEF_START_CYCLES = 2;
    localparam int unsigned DEF_TIMEOUT      = 32'h0000_FFFF;
    localparam int unsigned RUN_ID_W         = 8;

    // Width of the inline init counter; it only ever holds START_CYCLES-1.
    function automatic int unsigned init_cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear
// has priority over enable.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max = &cnt_q;
    assign q      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run sequencer in front of the processor: pulses its init line, counts run
// cycles until halt, timeout or abort, and reports status to the host.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int unsigned CW           = DEF_CW,
    parameter int unsigned START_CYCLES = DEF_START_CYCLES,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic                abort,
    input  logic                dut_halt,
    output logic                dut_start,
    output logic                busy,
    output logic                done,
    output logic                timed_out,
    output logic [CW-1:0]       cycle_ct,
    output logic [RUN_ID_W-1:0] run_id,
    output run_state_t          state_dbg
);

    localparam int unsigned      ICW          = init_cw(START_CYCLES);
    localparam logic [ICW-1:0]   INIT_LOAD    = ICW'(START_CYCLES - 1);
    localparam logic             TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(TIMEOUT - 1);

    run_state_t          state_q, state_d;
    logic [ICW-1:0]      init_cnt_q, init_cnt_d;
    logic                timed_out_q, timed_out_d;
    logic [RUN_ID_W-1:0] run_id_q, run_id_d;
    logic                dut_start_q, dut_start_d;
    logic                ct_clr;
    logic                ct_en;
    logic                ct_at_max;

    sat_counter #(.W(CW)) u_cycle_ct (
        .clk    (clk),
        .rst_n  (reset_n),
        .clr    (ct_clr),
        .en     (ct_en),
        .q      (cycle_ct),
        .at_max (ct_at_max)
    );

    // Host interface: go is a request level sampled only in IDLE/DONE (ignored
    // while busy); abort is honoured only in INIT/RUN. No ready/ack is returned:
    // busy/done are the status, and go beats abort when both arrive in IDLE/DONE.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        timed_out_d = timed_out_q;
        run_id_d    = run_id_q;
        ct_clr      = 1'b0;
        ct_en       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d     = INIT;
                    init_cnt_d  = INIT_LOAD;
                    timed_out_d = 1'b0;
                    ct_clr      = 1'b1;
                end
            end
            INIT: begin
                // dut_halt is meaningless while the processor is held in init.
                if (abort) begin
                    state_d = IDLE;
                end else if (init_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q - ICW'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dut_halt) begin
                    state_d  = DONE;
                    run_id_d = run_id_q + RUN_ID_W'(1);
                end else begin
                    ct_en = 1'b1;
                    if (TIMEOUT_EN && (cycle_ct == TIMEOUT_LAST)) begin
                        state_d     = DONE;
                        timed_out_d = 1'b1;
                        run_id_d    = run_id_q + RUN_ID_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        dut_start_d = (state_d == INIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            init_cnt_q  <= '0;
            timed_out_q <= 1'b0;
            run_id_q    <= '0;
            dut_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            timed_out_q <= timed_out_d;
            run_id_q    <= run_id_d;
            dut_start_q <= dut_start_d;
        end
    end

    assign dut_start = dut_start_q;
    assign busy      = (state_q == INIT) || (state_q == RUN);
    assign done      = (state_q == DONE);
    assign timed_out = timed_out_q;
    assign run_id    = run_id_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: one instance with a 20-cycle timeout and
// one narrow, timeout-free instance for saturation and run_id wrap.
module tb_run_controller;
    import run_controller_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic       a_go = 1'b0, a_abort = 1'b0, a_halt = 1'b0;
    logic       a_start, a_busy, a_done, a_to;
    logic [15:0] a_ct;
    logic [7:0]  a_id;
    run_state_t  a_st;

    logic       b_go = 1'b0, b_abort = 1'b0, b_halt = 1'b0;
    logic       b_start, b_busy, b_done, b_to;
    logic [3:0]  b_ct;
    logic [7:0]  b_id;
    run_state_t  b_st;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_controller #(.CW(16), .START_CYCLES(2), .TIMEOUT(20)) u_a (
        .clk(clk), .reset_n(reset_n), .go(a_go), .abort(a_abort), .dut_halt(a_halt),
        .dut_start(a_start), .busy(a_busy), .done(a_done), .timed_out(a_to),
        .cycle_ct(a_ct), .run_id(a_id), .state_dbg(a_st)
    );

    run_controller #(.CW(4), .START_CYCLES(1), .TIMEOUT(0)) u_b (
        .clk(clk), .reset_n(reset_n), .go(b_go), .abort(b_abort), .dut_halt(b_halt),
        .dut_start(b_start), .busy(b_busy), .done(b_done), .timed_out(b_to),
        .cycle_ct(b_ct), .run_id(b_id), .state_dbg(b_st)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) step();
        chk("rst_start", a_start, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_to", a_to, 0);
        chk("rst_ct", a_ct, 0);
        chk("rst_id", a_id, 0);
        chk("rst_state", a_st, IDLE);
        reset_n = 1'b1;
        step();

        // T2 normal run, halt after 10 run cycles
        a_go = 1'b1; step(); a_go = 1'b0;
        chk("t2_start_c1", a_start, 1);
        chk("t2_busy_init", a_busy, 1);
        chk("t2_state_init", a_st, INIT);
        step();
        chk("t2_start_c2", a_start, 1);
        step();
        chk("t2_start_off", a_start, 0);
        chk("t2_state_run", a_st, RUN);
        chk("t2_ct_run0", a_ct, 0);
        repeat (10) step();
        chk("t2_ct10", a_ct, 10);
        a_halt = 1'b1; step(); a_halt = 1'b0;
        chk("t2_done", a_done, 1);
        chk("t2_ct", a_ct, 10);
        chk("t2_to", a_to, 0);
        chk("t2_id", a_id, 1);
        chk("t2_busy", a_busy, 0);
        step();
        chk("t2_ct_hold", a_ct, 10);
        chk("t2_done_level", a_done, 1);
        chk("t2_start_done", a_start, 0);

        // T3 timeout at 20
        a_go = 1'b1; step(); a_go = 1'b0;
        chk("t3_ct_clr", a_ct, 0);
        chk("t3_done_clr", a_done, 0);
        step(); step();
        n = 0;
        while (!a_done && n < 40) begin
            step();
            n++;
        end
        chk("t3_cycles", n, 20);
        chk("t3_done", a_done, 1);
        chk("t3_to", a_to, 1);
        chk("t3_ct", a_ct, 20);
        chk("t3_id", a_id, 2);

        // T4 halt on the timeout cycle: halt wins
        a_go = 1'b1; step(); a_go = 1'b0;
        chk("t4_to_clr", a_to, 0);
        step(); step();
        repeat (19) step();
        chk("t4_ct19", a_ct, 19);
        a_halt = 1'b1; step(); a_halt = 1'b0;
        chk("t4_done", a_done, 1);
        chk("t4_to", a_to, 0);
        chk("t4_ct", a_ct, 19);
        chk("t4_id", a_id, 3);

        // T5 go and halt ignored in INIT, abort in RUN at count 5
        a_go = 1'b1; step();
        a_halt = 1'b1; step();
        chk("t5_init_hold", a_st, INIT);
        chk("t5_init_start", a_start, 1);
        step(); a_go = 1'b0; a_halt = 1'b0;
        chk("t5_run", a_st, RUN);
        chk("t5_ct0", a_ct, 0);
        repeat (5) step();
        a_abort = 1'b1; step(); a_abort = 1'b0;
        chk("t5_state", a_st, IDLE);
        chk("t5_busy", a_busy, 0);
        chk("t5_done", a_done, 0);
        chk("t5_ct", a_ct, 5);
        chk("t5_id", a_id, 3);

        // Abort in INIT, then go+abort together in IDLE
        a_go = 1'b1; step(); a_go = 1'b0;
        a_abort = 1'b1; step(); a_abort = 1'b0;
        chk("ab_init_state", a_st, IDLE);
        chk("ab_init_start", a_start, 0);
        a_go = 1'b1; a_abort = 1'b1; step(); a_go = 1'b0; a_abort = 1'b0;
        chk("go_beats_abort", a_st, INIT);

        // T1 asynchronous reset during INIT and mid-RUN
        #2 reset_n = 1'b0; #1;
        chk("t1_init_start", a_start, 0);
        chk("t1_init_busy", a_busy, 0);
        reset_n = 1'b1;
        step();
        a_go = 1'b1; step(); a_go = 1'b0;
        step(); step();
        repeat (3) step();
        a_halt = 1'b1; step(); a_halt = 1'b0;
        chk("t1_pre_id", a_id, 1);
        a_go = 1'b1; step(); a_go = 1'b0;
        step(); step();
        repeat (4) step();
        chk("t1_pre_ct", a_ct, 4);
        #2 reset_n = 1'b0; #1;
        chk("t1_ct", a_ct, 0);
        chk("t1_id", a_id, 0);
        chk("t1_busy", a_busy, 0);
        chk("t1_start", a_start, 0);
        chk("t1_state", a_st, IDLE);
        reset_n = 1'b1;
        step();

        // T6 saturation with CW=4, no timeout, and run_id wrap
        b_go = 1'b1; step(); b_go = 1'b0;
        chk("t6_start1", b_start, 1);
        step();
        chk("t6_start_off", b_start, 0);
        chk("t6_run", b_st, RUN);
        repeat (20) step();
        chk("t6_sat", b_ct, 15);
        chk("t6_busy", b_busy, 1);
        chk("t6_to", b_to, 0);
        b_halt = 1'b1; step(); b_halt = 1'b0;
        chk("t6_done", b_done, 1);
        chk("t6_ct_done", b_ct, 15);
        chk("t6_id1", b_id, 1);
        b_go = 1'b1; step(); b_go = 1'b0;
        chk("t6_rerun_ct", b_ct, 0);
        chk("t6_rerun_done", b_done, 0);
        step();
        b_halt = 1'b1; step(); b_halt = 1'b0;
        chk("t6_id2", b_id, 2);
        for (int r = 2; r < 255; r++) begin
            b_go = 1'b1; step(); b_go = 1'b0;
            step();
            b_halt = 1'b1; step(); b_halt = 1'b0;
        end
        chk("t6_id255", b_id, 255);
        b_go = 1'b1; step(); b_go = 1'b0;
        step();
        b_halt = 1'b1; step(); b_halt = 1'b0;
        chk("t6_id_wrap", b_id, 0);
        chk("t6_wrap_done", b_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
